// File: rtl/floating_point_subtractor_sequential_if.sv
// Start/busy/done operand and result bundle for the sequential FP subtractor.
// The requester drives start/a/b; the subtractor drives result/overflow/busy/done.
// Single-issue: start is only honoured while busy is low.
interface floating_point_subtractor_sequential_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (output start, a, b, input result, overflow, busy, done);
    modport slave  (input start, a, b, output result, overflow, busy, done);
endinterface

// File: rtl/floating_point_subtractor_sequential.sv
// Sequential IEEE-754 single-precision subtractor, result = a - b (denormals flushed, Inf/NaN saturate).
// Latency 5 + L cycles from the start-sampling edge, L = number of one-bit normalisation left shifts.
// No backpressure: start is accepted only in IDLE; start while busy is dropped. ROUND_NEAREST_EN selects RNE in PACK, else truncation.
module floating_point_subtractor_sequential #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int GUARD_BITS = 3
) (
    input  logic clk,
    input  logic rst,
    floating_point_subtractor_sequential_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = 1 + MAN_W + GUARD_BITS;   // hidden + mantissa + guard
    localparam int SUM_W = SIG_W + 1;                // plus carry
    localparam int EW    = EXP_W + 1;                // headroom to detect exp >= max
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORM, PACK} state_t;

    state_t state, state_next;

    logic [W-1:0]     op_a, op_b;
    logic             sgn_a, sgn_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [SIG_W-1:0] sig_a, sig_b;
    logic             sat, sat_sign;
    logic [SIG_W-1:0] x_sig, y_sig;
    logic             eff_sub;
    logic             sgn_r;
    logic [EW-1:0]    exp_w;
    logic [SUM_W-1:0] mag;

    // ALIGN: larger magnitude becomes X, Y shifted right with shifted-out bits folded into the LSB
    logic             a_big;
    logic [EXP_W-1:0] big_exp, diff;
    logic [SIG_W-1:0] big_sig, small_sig, y_aligned;
    logic             big_sgn, lost;
    always_comb begin
        a_big     = {exp_a, sig_a} >= {exp_b, sig_b};
        big_exp   = a_big ? exp_a : exp_b;
        big_sig   = a_big ? sig_a : sig_b;
        big_sgn   = a_big ? sgn_a : sgn_b;
        small_sig = a_big ? sig_b : sig_a;
        diff      = big_exp - (a_big ? exp_b : exp_a);
        // a shift of SIG_W or more empties the mask, so Y collapses to the sticky bit alone
        lost      = |(small_sig & ~({SIG_W{1'b1}} << diff));
        y_aligned = (small_sig >> diff) | {{(SIG_W-1){1'b0}}, lost};
    end

    logic carry, lead, is_zero, flush, norm_done;
    assign carry     = mag[SUM_W-1];
    assign lead      = mag[SUM_W-2];
    assign is_zero   = (mag == '0);
    assign flush     = (exp_w <= EW'(1));
    assign norm_done = carry | lead | is_zero | flush;

    // PACK: drop hidden bit, optionally round, then saturate on exponent overflow
    logic             round_up;
    logic [MAN_W:0]   man_inc;
    logic [EW-1:0]    exp_p;
    logic             pack_ovf;
    logic [W-1:0]     pack_res;
`ifdef ROUND_NEAREST_EN
    always_comb begin
        round_up = mag[GUARD_BITS-1] & (mag[GUARD_BITS] | (|mag[GUARD_BITS-2:0]));
    end
`else
    logic unused_guard;
    assign unused_guard = ^mag[GUARD_BITS-1:0];
    always_comb begin
        round_up = 1'b0;
    end
`endif
    always_comb begin
        man_inc  = {1'b0, mag[SIG_W-2:GUARD_BITS]} + {{MAN_W{1'b0}}, round_up};
        exp_p    = exp_w + {{(EW-1){1'b0}}, man_inc[MAN_W]};
        pack_ovf = sat | (exp_p >= EXP_MAX);
        pack_res = pack_ovf ? {(sat ? sat_sign : sgn_r), {(W-1){1'b1}}}
                            : {sgn_r, exp_p[EXP_W-1:0], man_inc[MAN_W-1:0]};
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next-state: fixed walk through the pipeline steps, NORM loops until normalised
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = UNPACK;
            UNPACK:  state_next = ALIGN;
            ALIGN:   state_next = ADDSUB;
            ADDSUB:  state_next = NORM;
            NORM:    if (norm_done) state_next = PACK;
            PACK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // datapath: each state updates only the registers it owns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0; op_b <= '0;
            sgn_a <= 1'b0; sgn_b <= 1'b0; exp_a <= '0; exp_b <= '0;
            sig_a <= '0; sig_b <= '0; sat <= 1'b0; sat_sign <= 1'b0;
            x_sig <= '0; y_sig <= '0; eff_sub <= 1'b0; sgn_r <= 1'b0;
            exp_w <= '0; mag <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_a <= bus.a;
                    op_b <= bus.b;
                end
                UNPACK: begin
                    sgn_a <= op_a[W-1];
                    sgn_b <= ~op_b[W-1];
                    exp_a <= op_a[W-2:MAN_W];
                    exp_b <= op_b[W-2:MAN_W];
                    sig_a <= (op_a[W-2:MAN_W] != '0) ? {1'b1, op_a[MAN_W-1:0], {GUARD_BITS{1'b0}}} : '0;
                    sig_b <= (op_b[W-2:MAN_W] != '0) ? {1'b1, op_b[MAN_W-1:0], {GUARD_BITS{1'b0}}} : '0;
                    sat      <= (&op_a[W-2:MAN_W]) | (&op_b[W-2:MAN_W]);
                    sat_sign <= (&op_a[W-2:MAN_W]) ? op_a[W-1] : ~op_b[W-1];
                end
                ALIGN: begin
                    x_sig   <= big_sig;
                    y_sig   <= y_aligned;
                    exp_w   <= {1'b0, big_exp};
                    sgn_r   <= big_sgn;
                    eff_sub <= sgn_a ^ sgn_b;
                end
                ADDSUB: begin
                    mag <= eff_sub ? ({1'b0, x_sig} - {1'b0, y_sig})
                                   : ({1'b0, x_sig} + {1'b0, y_sig});
                end
                NORM: begin
                    if (carry) begin
                        mag   <= {1'b0, mag[SUM_W-1:2], mag[1] | mag[0]};
                        exp_w <= exp_w + EW'(1);
                    end else if (lead) begin
                        mag <= mag;
                    end else if (is_zero || flush) begin
                        mag   <= '0;
                        exp_w <= '0;
                        sgn_r <= 1'b0;
                    end else begin
                        mag   <= mag << 1;
                        exp_w <= exp_w - EW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // handshake outputs: busy from accept to PACK exit, done/result registered leaving PACK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.result   <= '0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.start) bus.busy <= 1'b1;
            if (state == PACK) begin
                bus.result   <= pack_res;
                bus.overflow <= pack_ovf;
                bus.done     <= 1'b1;
                bus.busy     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_floating_point_subtractor_sequential.sv
// Bench for the sequential FP subtractor: directed cases plus randomized operands.
// Expected results come from an exact wide-integer model; a monitor checks each done.
// Stimulus waits for busy low before each start.
module tb_floating_point_subtractor_sequential;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    floating_point_subtractor_sequential_if ifc ();

    floating_point_subtractor_sequential dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;   // -1: latency not checked
        int          t0;    // index of the start-sampling edge
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Exact model: operands become wide integers (significand << exponent), the
    // difference is formed exactly, then normalised, flushed, rounded and saturated.
    function automatic logic [32:0] model(input logic [31:0] xa, input logic [31:0] xb);
        logic         sa, sb, s;
        int           ea, eb, p, e;
        logic [299:0] va, vb, mag, one, rem, half;
        logic [23:0]  man;
        sa = xa[31];
        sb = ~xb[31];
        ea = int'(xa[30:23]);
        eb = int'(xb[30:23]);
        if (ea == 255) return {1'b1, sa, 31'h7FFFFFFF};
        if (eb == 255) return {1'b1, sb, 31'h7FFFFFFF};
        va = (ea == 0) ? '0 : (300'({1'b1, xa[22:0]}) << ea);
        vb = (eb == 0) ? '0 : (300'({1'b1, xb[22:0]}) << eb);
        if (sa == sb)      begin mag = va + vb; s = sa; end
        else if (va >= vb) begin mag = va - vb; s = sa; end
        else               begin mag = vb - va; s = sb; end
        if (mag == '0) return 33'd0;
        p = 299;
        while (!mag[p]) p--;
        e = p - 23;
        if (e < 1) return 33'd0;
        man = {1'b0, 23'(mag >> (p - 23))};
`ifdef ROUND_NEAREST_EN
        one  = 300'd1;
        rem  = mag & ((one << (p - 23)) - one);
        half = one << (p - 24);
        if (rem > half || (rem == half && man[0])) man = man + 24'd1;
        if (man[23]) begin
            man = '0;
            e   = e + 1;
        end
`else
        one = '0; rem = '0; half = '0;
`endif
        if (e >= 255) return {1'b1, s, 31'h7FFFFFFF};
        return {1'b0, s, 8'(e), man[22:0]};
    endfunction

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t x;
        if (!rst && ifc.done) begin
            check("done_single_cycle", {31'd0, done_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h with nothing outstanding", ifc.result);
            end else begin
                x = sb_q.pop_front();
                check("result", ifc.result, x.res);
                check("overflow", {31'd0, ifc.overflow}, {31'd0, x.ovf});
                check("busy_at_done", {31'd0, ifc.busy}, 32'd0);
                if (x.lat >= 0) check("latency", 32'(cyc - x.t0), 32'(x.lat));
            end
        end
        done_prev = ifc.done;
    end

    // one start pulse at a negedge; returns at the negedge after the sampling edge
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] er,
                         input logic eo, input int el, input bit track);
        exp_t x;
        int   n = 0;
        while (ifc.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ifc.busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles", ifc.busy, n);
        end
        ifc.a     = xa;
        ifc.b     = xb;
        ifc.start = 1'b1;
        if (track) begin
            x.res = er; x.ovf = eo; x.lat = el; x.t0 = cyc + 1;
            sb_q.push_back(x);
        end
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.a     = $urandom;
        ifc.b     = $urandom;
    endtask

    task automatic issue_model(input logic [31:0] xa, input logic [31:0] xb);
        logic [32:0] m;
        m = model(xa, xb);
        issue(xa, xb, m[31:0], m[32], -1, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          mode, e;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        #1;
        check("reset_result", ifc.result, 32'd0);
        check("reset_overflow", {31'd0, ifc.overflow}, 32'd0);
        check("reset_busy", {31'd0, ifc.busy}, 32'd0);
        check("reset_done", {31'd0, ifc.done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        issue(32'h40A00000, 32'h40400000, 32'h40000000, 1'b0, 6, 1'b1);
        drain();
        issue(32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 5, 1'b1);
        drain();
        issue(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7FFFFFFF, 1'b1, 5, 1'b1);
        drain();
        issue(32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFFFFFFFF, 1'b1, 5, 1'b1);
        drain();
`ifdef ROUND_NEAREST_EN
        issue(32'h3F800000, 32'h33000000, 32'h3F800000, 1'b0, 6, 1'b1);
`else
        issue(32'h3F800000, 32'h33000000, 32'h3F7FFFFF, 1'b0, 6, 1'b1);
`endif
        drain();

        // start while busy is ignored: one done, result untouched
        issue(32'hC0000000, 32'h3F800000, 32'hC0400000, 1'b0, 5, 1'b1);
        ifc.start = 1'b1;
        ifc.a     = 32'h3F800000;
        ifc.b     = 32'h40000000;
        repeat (2) @(negedge clk);
        ifc.start = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("held_result", ifc.result, 32'hC0400000);

        // reset mid-operation aborts with no done
        issue(32'h40A00000, 32'h40400000, 32'h0, 1'b0, -1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_result", ifc.result, 32'd0);
        check("abort_overflow", {31'd0, ifc.overflow}, 32'd0);
        check("abort_busy", {31'd0, ifc.busy}, 32'd0);
        check("abort_done", {31'd0, ifc.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue(32'h40A00000, 32'h40400000, 32'h40000000, 1'b0, 6, 1'b1);
        drain();

        // randomized operands, biased towards cancellation, zeros, Inf/NaN and overflow
        for (int i = 0; i < 300; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rs   = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 9);
            case (mode)
                0: rb = ra;
                1: rb = ra ^ 32'h80000000;
                2, 3, 4, 5: begin
                    e = int'(ra[30:23]) + $urandom_range(0, 6) - 3;
                    if (e < 0) e = 0;
                    if (e > 254) e = 254;
                    rb = {rs, 8'(e), 23'($urandom)};
                end
                6: if (rs) rb[30:23] = 8'h00; else ra[30:23] = 8'h00;
                7: if (rs) rb[30:23] = 8'hFF; else ra[30:23] = 8'hFF;
                8: begin
                    ra[30:23] = 8'hFE;
                    rb = {~ra[31], 8'hFE, 23'($urandom)};
                end
                default: ;
            endcase
            issue_model(ra, rb);
        end
        drain();
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
